// File: rtl/chesssoc_spi_burst_ctrl.sv
// Burst sequencer driving the 8-bit SPI master register port: SS_n held low across a multi-byte burst.
// Optional SPI_ERR_CHECK_EN: read/clear the master status E bit after the last byte and report it on err.
module chesssoc_spi_burst_ctrl #(
  parameter int unsigned LEN_W   = 8,
  parameter logic [15:0] SS_MASK = 16'h0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             err,
  output logic             spi_select,
  output logic [2:0]       spi_mem_addr,
  output logic             spi_read_n,
  output logic             spi_write_n,
  output logic [15:0]      spi_wdata,
  input  logic [15:0]      spi_rdata,
  input  logic             spi_readyfordata,
  input  logic             spi_dataavailable
);

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_RX   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TX   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_CTL  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_SS   = ADDR_W'(5);
  localparam logic [DATA_W-1:0] CTL_SSO   = DATA_W'(16'h0400);

  typedef enum logic [3:0] {
    IDLE,
    SEL_WR,
    CTL_ON,
    WAIT_TX,
    TX_WR,
    WAIT_RX,
    RX_RD,
`ifdef SPI_ERR_CHECK_EN
    STAT_RD,
    STAT_CLR,
`endif
    CTL_OFF,
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        step;       // 0: idle setup cycle, 1: bus ph0, 2: bus ph1
  logic [LEN_W-1:0]  remaining;
  logic              acc_en;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_last;
`ifdef SPI_ERR_CHECK_EN
  logic              err_seen;
`endif
  logic              unused_rdata;

  assign unused_rdata = ^spi_rdata[15:8];
  assign acc_last     = acc_en && (step == 2'd2);

  // Register access described by the current state
  always_comb begin
    acc_en   = 1'b0;
    acc_wr   = 1'b1;
    acc_addr = ADDR_RX;
    acc_data = '0;
    case (state)
      SEL_WR:   begin acc_en = 1'b1; acc_addr = ADDR_SS;  acc_data = SS_MASK; end
      CTL_ON:   begin acc_en = 1'b1; acc_addr = ADDR_CTL; acc_data = CTL_SSO; end
      TX_WR:    begin acc_en = 1'b1; acc_addr = ADDR_TX;  acc_data = {8'h00, tx_data}; end
      RX_RD:    begin acc_en = 1'b1; acc_wr = 1'b0; acc_addr = ADDR_RX; end
`ifdef SPI_ERR_CHECK_EN
      STAT_RD:  begin acc_en = 1'b1; acc_wr = 1'b0; acc_addr = ADDR_STAT; end
      STAT_CLR: begin acc_en = 1'b1; acc_addr = ADDR_STAT; end
`endif
      CTL_OFF:  begin acc_en = 1'b1; acc_addr = ADDR_CTL; end
      default:  acc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      step         <= 2'd0;
      remaining    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tx_ready     <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      err          <= 1'b0;
      spi_select   <= 1'b0;
      spi_mem_addr <= '0;
      spi_read_n   <= 1'b1;
      spi_write_n  <= 1'b1;
      spi_wdata    <= '0;
`ifdef SPI_ERR_CHECK_EN
      err_seen     <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      err      <= 1'b0;

      // Two-cycle bus access preceded by one idle cycle
      if (acc_en) begin
        case (step)
          2'd0: begin
            spi_select   <= 1'b1;
            spi_mem_addr <= acc_addr;
            spi_wdata    <= acc_data;
            spi_write_n  <= ~acc_wr;
            spi_read_n   <= acc_wr;
            tx_ready     <= (state == TX_WR);
            step         <= 2'd1;
          end
          2'd1: step <= 2'd2;
          default: begin
            spi_select   <= 1'b0;
            spi_mem_addr <= '0;
            spi_wdata    <= '0;
            spi_write_n  <= 1'b1;
            spi_read_n   <= 1'b1;
            step         <= 2'd0;
          end
        endcase
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= SEL_WR;
              busy      <= 1'b1;
              remaining <= len;
`ifdef SPI_ERR_CHECK_EN
              err_seen  <= 1'b0;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEL_WR:  if (acc_last) state <= CTL_ON;
        CTL_ON:  if (acc_last) state <= WAIT_TX;
        WAIT_TX: if (tx_valid && spi_readyfordata) state <= TX_WR;
        TX_WR:   if (acc_last) state <= WAIT_RX;
        WAIT_RX: if (spi_dataavailable) state <= RX_RD;
        RX_RD: begin
          if (acc_last) begin
            rx_data  <= spi_rdata[7:0];
            rx_valid <= 1'b1;
            if (remaining != '0) remaining <= remaining - LEN_W'(1);
            if (remaining > LEN_W'(1)) begin
              state <= WAIT_TX;
            end else begin
`ifdef SPI_ERR_CHECK_EN
              state <= STAT_RD;
`else
              state <= CTL_OFF;
`endif
            end
          end
        end
`ifdef SPI_ERR_CHECK_EN
        STAT_RD: begin
          if (acc_last) begin
            err_seen <= spi_rdata[8];
            state    <= spi_rdata[8] ? STAT_CLR : CTL_OFF;
          end
        end
        STAT_CLR: if (acc_last) state <= CTL_OFF;
`endif
        CTL_OFF: begin
          if (acc_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
`ifdef SPI_ERR_CHECK_EN
            err   <= err_seen;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chesssoc_spi_burst_ctrl.sv
// Directed bench for chesssoc_spi_burst_ctrl with a behavioural SPI master register model (MISO = tx ^ 8'h99).
module tb_chesssoc_spi_burst_ctrl;

  localparam int SHIFT_CLKS = 160;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic        busy, done, tx_ready, rx_valid, err;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid;
  logic        spi_select, spi_read_n, spi_write_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_wdata, spi_rdata;
  logic        spi_readyfordata, spi_dataavailable;

  always #10 clk = ~clk;

  chesssoc_spi_burst_ctrl #(.LEN_W(8), .SS_MASK(16'h0001)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .busy(busy), .done(done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .err(err),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
    .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_readyfordata(spi_readyfordata), .spi_dataavailable(spi_dataavailable)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] acc(input logic wr, input logic [2:0] a, input logic [15:0] d);
    return {wr, a, d};
  endfunction

  // Monitor / master model state
  logic [19:0] acc_log [0:255];
  logic [7:0]  rx_log  [0:255];
  logic [7:0]  tx_tab  [0:255];
  int acc_n = 0, rx_n = 0, done_cnt = 0, txr_cnt = 0, err_cnt = 0, bad_err = 0;
  int ss_rise = 0, len_err = 0, stab_err = 0, sel_cnt = 0, shift = 0;
  int tx_total = 0, tx_idx = 0, hold_idx = -1, hold_len = 0, hold_seen = 0;
  logic [19:0] cur_acc, cur;
  logic [15:0] m_ssen, m_ctl;
  logic [7:0]  m_tx, m_rx;
  logic        ss_low, ss_low_prev = 1'b0;
  logic        force_e = 1'b0, e_clr = 1'b0;

  initial begin
    spi_readyfordata = 1'b1;
    spi_dataavailable = 1'b0;
    spi_rdata = 16'h0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    m_ssen = 16'h0; m_ctl = 16'h0; m_tx = 8'h0; m_rx = 8'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_ssen = 16'h0; m_ctl = 16'h0; m_rx = 8'h0; shift = 0; sel_cnt = 0;
        spi_readyfordata = 1'b1; spi_dataavailable = 1'b0; spi_rdata = 16'h0;
      end else begin
        if (done) done_cnt++;
        if (err) begin err_cnt++; if (!done) bad_err++; end
        if (rx_valid) begin rx_log[rx_n] = rx_data; rx_n++; end
        if (tx_ready) begin txr_cnt++; tx_idx++; end
        cur = {~spi_write_n, spi_mem_addr, spi_wdata};
        if (spi_select) begin
          sel_cnt++;
          if (spi_read_n == spi_write_n) stab_err++;
          if (sel_cnt == 1) cur_acc = cur;
          else if (cur != cur_acc) stab_err++;
          if (sel_cnt == 2) begin
            acc_log[acc_n] = cur_acc; acc_n++;
            if (!spi_write_n) begin
              case (spi_mem_addr)
                3'd5: m_ssen = spi_wdata;
                3'd3: m_ctl = spi_wdata;
                3'd2: e_clr = 1'b1;
                3'd1: begin m_tx = spi_wdata[7:0]; shift = SHIFT_CLKS; spi_readyfordata = 1'b0; end
                default: ;
              endcase
            end else if (spi_mem_addr == 3'd0) begin
              spi_dataavailable = 1'b0;
            end
          end
        end else begin
          if (sel_cnt != 0 && sel_cnt != 2) len_err++;
          sel_cnt = 0;
          if (!spi_read_n || !spi_write_n || spi_mem_addr != 3'd0 || spi_wdata != 16'h0) stab_err++;
        end
        if (shift > 0) begin
          shift--;
          if (shift == 0) begin
            m_rx = m_tx ^ 8'h99;
            spi_dataavailable = 1'b1;
            spi_readyfordata = 1'b1;
          end
        end
        if (spi_mem_addr == 3'd0)      spi_rdata = {8'h00, m_rx};
        else if (spi_mem_addr == 3'd2) spi_rdata = {7'h00, force_e & ~e_clr, 8'h00};
        else                           spi_rdata = 16'h0;
      end
      ss_low = m_ctl[10] && (m_ssen != 16'h0);
      if (ss_low_prev && !ss_low) ss_rise++;
      ss_low_prev = ss_low;
      tx_valid = (tx_idx < tx_total) && !(tx_idx == hold_idx && hold_seen < hold_len);
      if (tx_idx == hold_idx && hold_seen < hold_len) hold_seen++;
      tx_data = tx_tab[tx_idx[7:0]];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0) begin ok = 1'b1; break; end
      step();
      cyc++;
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_tab[tx_total] = b;
    tx_total++;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start = 1'b1;
    len = n;
    step();
    start = 1'b0;
  endtask

  task automatic check_accs(input string tag, input int base, input logic [19:0] exp [$]);
    check({tag, "_acc_n"}, 32'(acc_n - base), 32'(exp.size()));
    foreach (exp[i])
      check($sformatf("%s_acc%0d", tag, i), 32'(acc_log[base + i]), 32'(exp[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ba, br, d0, s0, t0, e0, cyc, a0;
    bit ok;
    logic [19:0] exp_q [$];

    reset_n = 1'b0; start = 1'b0; len = 8'h0;
    repeat (3) step();
    check("rst_ctl", 32'({busy, done, tx_ready, rx_valid, err}), 32'(5'b0));
    check("rst_bus", 32'({spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wdata}),
          32'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0}));
    reset_n = 1'b1;
    repeat (2) step();

    // len=1, 0xA5 -> 0x3C
    ba = acc_n; br = rx_n; d0 = done_cnt; s0 = ss_rise; t0 = txr_cnt;
    push_tx(8'hA5);
    pulse_start(8'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(d0, 2000, ok, cyc);
    check("t1_done_seen", 32'(ok), 32'd1);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    repeat (3) step();
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    exp_q = '{acc(1, 5, 16'h0001), acc(1, 3, 16'h0400), acc(1, 1, 16'h00A5),
              acc(0, 0, 16'h0), acc(1, 3, 16'h0000)};
    check_accs("t1", ba, exp_q);
    check("t1_rx_n", 32'(rx_n - br), 32'd1);
    check("t1_rx0", 32'(rx_log[br]), 32'h3C);
    check("t1_txr", 32'(txr_cnt - t0), 32'd1);
    check("t1_ss_rise", 32'(ss_rise - s0), 32'd1);

    // len=3, 01/02/03
    ba = acc_n; br = rx_n; d0 = done_cnt; s0 = ss_rise; t0 = txr_cnt;
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    pulse_start(8'd3);
    wait_done(d0, 3000, ok, cyc);
    check("t2_done_seen", 32'(ok), 32'd1);
    check("t2_cyc_range", 32'(cyc >= 3 * SHIFT_CLKS && cyc <= 620), 32'd1);
    repeat (3) step();
    exp_q = '{acc(1, 5, 16'h0001), acc(1, 3, 16'h0400),
              acc(1, 1, 16'h0001), acc(0, 0, 16'h0), acc(1, 1, 16'h0002), acc(0, 0, 16'h0),
              acc(1, 1, 16'h0003), acc(0, 0, 16'h0), acc(1, 3, 16'h0000)};
    check_accs("t2", ba, exp_q);
    check("t2_txr", 32'(txr_cnt - t0), 32'd3);
    check("t2_rx_n", 32'(rx_n - br), 32'd3);
    check("t2_rx0", 32'(rx_log[br]), 32'h98);
    check("t2_rx1", 32'(rx_log[br + 1]), 32'h9B);
    check("t2_rx2", 32'(rx_log[br + 2]), 32'h9A);
    check("t2_ss_rise", 32'(ss_rise - s0), 32'd1);

    // len=0: done next cycle, no bus traffic
    ba = acc_n; d0 = done_cnt;
    pulse_start(8'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    step();
    check("t3_done_drop", 32'(done), 32'd0);
    repeat (10) step();
    check("t3_acc_n", 32'(acc_n - ba), 32'd0);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // tx_valid withheld 500 cycles before byte 2
    ba = acc_n; br = rx_n; d0 = done_cnt; t0 = txr_cnt;
    hold_len = 500; hold_idx = tx_total + 1;
    push_tx(8'h11); push_tx(8'h22);
    pulse_start(8'd2);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rx_n > br) begin ok = 1'b1; break; end
      step();
    end
    check("t4_rx0_seen", 32'(ok), 32'd1);
    repeat (20) step();
    a0 = acc_n;
    repeat (230) step();
    check("t4_acc_frozen", 32'(acc_n), 32'(a0));
    check("t4_busy_hold", 32'(busy), 32'd1);
    check("t4_ss_low_hold", 32'(ss_low_prev), 32'd1);
    check("t4_txr_hold", 32'(txr_cnt - t0), 32'd1);
    wait_done(d0, 3000, ok, cyc);
    check("t4_done_seen", 32'(ok), 32'd1);
    repeat (3) step();
    check("t4_acc_n", 32'(acc_n - ba), 32'd7);
    check("t4_rx0", 32'(rx_log[br]), 32'h88);
    check("t4_rx1", 32'(rx_log[br + 1]), 32'hBB);

    // reset during byte 2, then a clean len=1 burst
    t0 = txr_cnt;
    push_tx(8'h44); push_tx(8'h55); push_tx(8'h66);
    pulse_start(8'd3);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (txr_cnt >= t0 + 2) begin ok = 1'b1; break; end
      step();
    end
    check("t5_byte2_sent", 32'(ok), 32'd1);
    repeat (50) step();
    reset_n = 1'b0;
    step();
    check("t5_rst_ctl", 32'({busy, done, tx_ready, rx_valid, err}), 32'(5'b0));
    check("t5_rst_bus", 32'({spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wdata}),
          32'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0}));
    tx_total = tx_idx;
    reset_n = 1'b1;
    repeat (2) step();
    ba = acc_n; br = rx_n; d0 = done_cnt;
    push_tx(8'h77);
    pulse_start(8'd1);
    wait_done(d0, 2000, ok, cyc);
    check("t5_done_seen", 32'(ok), 32'd1);
    repeat (3) step();
    check("t5_acc_n", 32'(acc_n - ba), 32'd5);
    check("t5_rx0", 32'(rx_log[br]), 32'hEE);

    // master status E forced
    ba = acc_n; br = rx_n; d0 = done_cnt; e0 = err_cnt;
    force_e = 1'b1;
    push_tx(8'hC3);
    pulse_start(8'd1);
    wait_done(d0, 2000, ok, cyc);
    check("t6_done_seen", 32'(ok), 32'd1);
    repeat (3) step();
    check("t6_rx0", 32'(rx_log[br]), 32'h5A);
`ifdef SPI_ERR_CHECK_EN
    exp_q = '{acc(1, 5, 16'h0001), acc(1, 3, 16'h0400), acc(1, 1, 16'h00C3), acc(0, 0, 16'h0),
              acc(0, 2, 16'h0), acc(1, 2, 16'h0000), acc(1, 3, 16'h0000)};
    check_accs("t6", ba, exp_q);
    check("t6_err_cnt", 32'(err_cnt - e0), 32'd1);
`else
    exp_q = '{acc(1, 5, 16'h0001), acc(1, 3, 16'h0400), acc(1, 1, 16'h00C3), acc(0, 0, 16'h0),
              acc(1, 3, 16'h0000)};
    check_accs("t6", ba, exp_q);
    check("t6_err_cnt", 32'(err_cnt - e0), 32'd0);
`endif

    check("bus_len_err", 32'(len_err), 32'd0);
    check("bus_stab_err", 32'(stab_err), 32'd0);
    check("err_without_done", 32'(bad_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
